// File: rtl/issue_hazard_unit_pkg.sv
// Shared core definitions for the issue/bypass pair.
// Register-tag layout, FSM states and bypass mux codes.
package issue_hazard_unit_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        BYP_RF   = 3'd0,
        BYP_LSU0 = 3'd1,
        BYP_LSU1 = 3'd2,
        BYP_WB0  = 3'd3,
        BYP_WB1  = 3'd4
    } byp_sel_e;

    typedef enum logic {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } iss_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic              ld;
    } hz_tag_t;

    localparam hz_tag_t TAG_NONE = '{valid: 1'b0, addr: '0, ld: 1'b0};

    // A valid tag already implies a written, non-zero destination
    function automatic logic src_hit(
        input logic              r,
        input logic [REG_AW-1:0] rs,
        input hz_tag_t           t
    );
        return r & t.valid & (t.addr == rs) & (rs != '0);
    endfunction

    // Writes to x0 never create a tag; bubbles are all-zero
    function automatic hz_tag_t mk_tag(
        input logic              iss,
        input logic              we,
        input logic              ld,
        input logic [REG_AW-1:0] rd
    );
        hz_tag_t t;
        t = TAG_NONE;
        if (iss & we & (rd != '0)) begin
            t.valid = 1'b1;
            t.addr  = rd;
            t.ld    = ld;
        end
        return t;
    endfunction

endpackage

// File: rtl/issue_hazard_unit_tag_stage.sv
// One destination-tag slot of the EX/LSU/WB tag pipeline.
// Clear wins over enable so a flush always empties the slot.
module hazard_tag_stage
    import issue_hazard_unit_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_en,
    input  logic    i_clr,
    input  hz_tag_t i_d,
    output hz_tag_t o_q
);

    hz_tag_t r_q;

    // Tag register: reset/clear to empty, otherwise load when enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= TAG_NONE;
        end else if (i_clr) begin
            r_q <= TAG_NONE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/issue_hazard_unit.sv
// Dual-issue hazard unit: picks lanes entering EX and
// tracks destination tags through EX -> LSU -> WB.
module issue_hazard_unit
    import issue_hazard_unit_pkg::*;
#(
    parameter int RA_W = REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_v0,
    input  logic            id_v1,
    input  logic [RA_W-1:0] id_rs1_0,
    input  logic [RA_W-1:0] id_rs2_0,
    input  logic [RA_W-1:0] id_rs1_1,
    input  logic [RA_W-1:0] id_rs2_1,
    input  logic            id_r1_0,
    input  logic            id_r2_0,
    input  logic            id_r1_1,
    input  logic            id_r2_1,
    input  logic [RA_W-1:0] id_rd0,
    input  logic [RA_W-1:0] id_rd1,
    input  logic            id_we0,
    input  logic            id_we1,
    input  logic            id_ld0,
    input  logic            id_ld1,
    input  logic            mem_stall,
    input  logic            flush,
    output logic            stall_id,
    output logic            ex_v0,
    output logic            ex_v1,
    output logic            wm0,
    output logic [RA_W-1:0] am0,
    output logic            wm1,
    output logic [RA_W-1:0] am1,
    output logic            ww0,
    output logic [RA_W-1:0] aw0,
    output logic            ww1,
    output logic [RA_W-1:0] aw1
);

    iss_state_e r_state;
    iss_state_e w_nxt;

    hz_tag_t w_ex0, w_ex1;
    hz_tag_t w_lsu0, w_lsu1;
    hz_tag_t w_wb0, w_wb1;
    hz_tag_t w_ex_d0, w_ex_d1;
    hz_tag_t w_p0;

    logic w_lu0, w_lu1;
    logic w_raw, w_waw;
    logic w_iss0, w_iss1, w_stall;
    logic w_adv;
    logic w_unused;

    // Load-use: any read source hits a load still in EX
    always_comb begin
        w_lu0 = id_v0 & (
            (src_hit(id_r1_0, id_rs1_0, w_ex0) & w_ex0.ld) |
            (src_hit(id_r1_0, id_rs1_0, w_ex1) & w_ex1.ld) |
            (src_hit(id_r2_0, id_rs2_0, w_ex0) & w_ex0.ld) |
            (src_hit(id_r2_0, id_rs2_0, w_ex1) & w_ex1.ld));
        w_lu1 = id_v1 & (
            (src_hit(id_r1_1, id_rs1_1, w_ex0) & w_ex0.ld) |
            (src_hit(id_r1_1, id_rs1_1, w_ex1) & w_ex1.ld) |
            (src_hit(id_r2_1, id_rs2_1, w_ex0) & w_ex0.ld) |
            (src_hit(id_r2_1, id_rs2_1, w_ex1) & w_ex1.ld));
    end

    // Intra-pair RAW/WAW against the lane0 destination
    always_comb begin
        w_p0  = mk_tag(1'b1, id_we0, 1'b0, id_rd0);
        w_raw = src_hit(id_r1_1, id_rs1_1, w_p0) |
                src_hit(id_r2_1, id_rs2_1, w_p0);
        w_waw = id_we0 & id_we1 & (id_rd0 == id_rd1) &
                (id_rd0 != '0);
    end

    // Issue FSM next-state and lane enables
    always_comb begin
        w_nxt   = r_state;
        w_iss0  = 1'b0;
        w_iss1  = 1'b0;
        w_stall = 1'b0;
        if (flush) begin
            w_nxt = ST_PAIR;
        end else if (mem_stall) begin
            w_stall = 1'b1;
        end else begin
            case (r_state)
                ST_PAIR: begin
                    if (w_lu0 | w_lu1) begin
                        w_stall = 1'b1;
                    end else if (id_v0 & id_v1 & (w_raw | w_waw)) begin
                        w_iss0  = 1'b1;
                        w_stall = 1'b1;
                        w_nxt   = ST_SECOND;
                    end else begin
                        w_iss0 = id_v0;
                        w_iss1 = id_v1;
                    end
                end
                ST_SECOND: begin
                    if (w_lu1) begin
                        w_stall = 1'b1;
                    end else begin
                        w_iss1 = 1'b1;
                        w_nxt  = ST_PAIR;
                    end
                end
                default: w_nxt = ST_PAIR;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PAIR;
        end else begin
            r_state <= w_nxt;
        end
    end

    assign w_adv   = ~mem_stall;
    assign w_ex_d0 = mk_tag(w_iss0, id_we0, id_ld0, id_rd0);
    assign w_ex_d1 = mk_tag(w_iss1, id_we1, id_ld1, id_rd1);

    hazard_tag_stage u_ex0 (
        .i_clk(clk), .i_rst(rst), .i_en(w_adv), .i_clr(flush),
        .i_d(w_ex_d0), .o_q(w_ex0)
    );
    hazard_tag_stage u_ex1 (
        .i_clk(clk), .i_rst(rst), .i_en(w_adv), .i_clr(flush),
        .i_d(w_ex_d1), .o_q(w_ex1)
    );
    hazard_tag_stage u_lsu0 (
        .i_clk(clk), .i_rst(rst), .i_en(w_adv), .i_clr(1'b0),
        .i_d(w_ex0), .o_q(w_lsu0)
    );
    hazard_tag_stage u_lsu1 (
        .i_clk(clk), .i_rst(rst), .i_en(w_adv), .i_clr(1'b0),
        .i_d(w_ex1), .o_q(w_lsu1)
    );
    hazard_tag_stage u_wb0 (
        .i_clk(clk), .i_rst(rst), .i_en(w_adv), .i_clr(1'b0),
        .i_d(w_lsu0), .o_q(w_wb0)
    );
    hazard_tag_stage u_wb1 (
        .i_clk(clk), .i_rst(rst), .i_en(w_adv), .i_clr(1'b0),
        .i_d(w_lsu1), .o_q(w_wb1)
    );

    assign stall_id = w_stall;
    assign ex_v0    = w_iss0;
    assign ex_v1    = w_iss1;
    assign wm0      = w_lsu0.valid;
    assign am0      = w_lsu0.addr;
    assign wm1      = w_lsu1.valid;
    assign am1      = w_lsu1.addr;
    assign ww0      = w_wb0.valid;
    assign aw0      = w_wb0.addr;
    assign ww1      = w_wb1.valid;
    assign aw1      = w_wb1.addr;

    // Load flag has no consumer once a tag reaches WB
    assign w_unused = w_wb0.ld ^ w_wb1.ld;

endmodule

// File: tb/tb_issue_hazard_unit.sv
// Randomized bench for issue_hazard_unit with an
// in-flight-instruction reference model plus directed cases.
module tb_issue_hazard_unit;

    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic id_v0, id_v1;
    logic [RA_W-1:0] id_rs1_0, id_rs2_0, id_rs1_1, id_rs2_1;
    logic id_r1_0, id_r2_0, id_r1_1, id_r2_1;
    logic [RA_W-1:0] id_rd0, id_rd1;
    logic id_we0, id_we1, id_ld0, id_ld1;
    logic mem_stall, flush;
    logic stall_id, ex_v0, ex_v1;
    logic wm0, wm1, ww0, ww1;
    logic [RA_W-1:0] am0, am1, aw0, aw1;

    issue_hazard_unit #(.RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .id_v0(id_v0), .id_v1(id_v1),
        .id_rs1_0(id_rs1_0), .id_rs2_0(id_rs2_0),
        .id_rs1_1(id_rs1_1), .id_rs2_1(id_rs2_1),
        .id_r1_0(id_r1_0), .id_r2_0(id_r2_0),
        .id_r1_1(id_r1_1), .id_r2_1(id_r2_1),
        .id_rd0(id_rd0), .id_rd1(id_rd1),
        .id_we0(id_we0), .id_we1(id_we1),
        .id_ld0(id_ld0), .id_ld1(id_ld1),
        .mem_stall(mem_stall), .flush(flush),
        .stall_id(stall_id), .ex_v0(ex_v0), .ex_v1(ex_v1),
        .wm0(wm0), .am0(am0), .wm1(wm1), .am1(am1),
        .ww0(ww0), .aw0(aw0), .ww1(ww1), .aw1(aw1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: in-flight producers per stage (0=EX,1=LSU,2=WB)
    int m_v[3][2];
    int m_a[3][2];
    int m_ld[3][2];
    bit m_sec;
    bit e_v0, e_v1, e_st;
    bit c_v0, c_v1, c_st, c_wm0, c_wm1, c_ww0;
    int c_am0, c_am1, c_aw0;

    function automatic void model_reset();
        for (int s = 0; s < 3; s++)
            for (int l = 0; l < 2; l++) begin
                m_v[s][l] = 0; m_a[s][l] = 0; m_ld[s][l] = 0;
            end
        m_sec = 0;
        e_st = 0;
    endfunction

    function automatic bit ld_hit(bit r, int rs);
        for (int j = 0; j < 2; j++)
            if (r && rs != 0 && m_v[0][j] != 0 && m_ld[0][j] != 0 &&
                m_a[0][j] == rs)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle();
        bit lu0, lu1, raw, waw, nsec;
        int nv[2], na[2], nl[2];
        @(negedge clk);
        if (!m_sec)
            assert (!(id_v1 && !id_v0))
            else $error("lane1 without lane0 in PAIR");
        lu0 = id_v0 && (ld_hit(id_r1_0, int'(id_rs1_0)) ||
                        ld_hit(id_r2_0, int'(id_rs2_0)));
        lu1 = id_v1 && (ld_hit(id_r1_1, int'(id_rs1_1)) ||
                        ld_hit(id_r2_1, int'(id_rs2_1)));
        raw = id_we0 && id_rd0 != 0 &&
              ((id_r1_1 && id_rs1_1 == id_rd0) ||
               (id_r2_1 && id_rs2_1 == id_rd0));
        waw = id_we0 && id_we1 && id_rd0 == id_rd1 && id_rd0 != 0;
        e_v0 = 0; e_v1 = 0; e_st = 0; nsec = m_sec;
        if (flush) nsec = 0;
        else if (mem_stall) e_st = 1;
        else if (!m_sec) begin
            if (lu0 || lu1) e_st = 1;
            else if (id_v0 && id_v1 && (raw || waw)) begin
                e_v0 = 1; e_st = 1; nsec = 1;
            end else begin
                e_v0 = id_v0; e_v1 = id_v1;
            end
        end else begin
            if (lu1) e_st = 1;
            else begin e_v1 = 1; nsec = 0; end
        end
        c_v0 = ex_v0; c_v1 = ex_v1; c_st = stall_id;
        c_wm0 = wm0; c_am0 = int'(am0); c_wm1 = wm1; c_am1 = int'(am1);
        c_ww0 = ww0; c_aw0 = int'(aw0);
        chk("ex_v0", ex_v0, e_v0);
        chk("ex_v1", ex_v1, e_v1);
        chk("stall_id", stall_id, e_st);
        chk("wm0", wm0, m_v[1][0]); chk("am0", am0, m_a[1][0]);
        chk("wm1", wm1, m_v[1][1]); chk("am1", am1, m_a[1][1]);
        chk("ww0", ww0, m_v[2][0]); chk("aw0", aw0, m_a[2][0]);
        chk("ww1", ww1, m_v[2][1]); chk("aw1", aw1, m_a[2][1]);
        nv[0] = (e_v0 && id_we0 && id_rd0 != 0) ? 1 : 0;
        nv[1] = (e_v1 && id_we1 && id_rd1 != 0) ? 1 : 0;
        na[0] = nv[0] != 0 ? int'(id_rd0) : 0;
        na[1] = nv[1] != 0 ? int'(id_rd1) : 0;
        nl[0] = nv[0] != 0 ? int'(id_ld0) : 0;
        nl[1] = nv[1] != 0 ? int'(id_ld1) : 0;
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            if (!mem_stall) begin
                m_v[2][l] = m_v[1][l]; m_a[2][l] = m_a[1][l];
                m_ld[2][l] = m_ld[1][l];
                m_v[1][l] = m_v[0][l]; m_a[1][l] = m_a[0][l];
                m_ld[1][l] = m_ld[0][l];
                m_v[0][l] = nv[l]; m_a[0][l] = na[l]; m_ld[0][l] = nl[l];
            end
            if (flush) begin
                m_v[0][l] = 0; m_a[0][l] = 0; m_ld[0][l] = 0;
            end
        end
        m_sec = nsec;
    endtask

    task automatic idle();
        id_v0 = 0; id_v1 = 0;
        id_rs1_0 = 0; id_rs2_0 = 0; id_rs1_1 = 0; id_rs2_1 = 0;
        id_r1_0 = 0; id_r2_0 = 0; id_r1_1 = 0; id_r2_1 = 0;
        id_rd0 = 0; id_rd1 = 0;
        id_we0 = 0; id_we1 = 0; id_ld0 = 0; id_ld1 = 0;
    endtask

    task automatic lane0(input int rs1, input bit r1, input int rs2,
                         input bit r2, input int rd, input bit we,
                         input bit ld);
        id_v0 = 1; id_rs1_0 = rs1[4:0]; id_r1_0 = r1;
        id_rs2_0 = rs2[4:0]; id_r2_0 = r2;
        id_rd0 = rd[4:0]; id_we0 = we; id_ld0 = ld;
    endtask

    task automatic lane1(input int rs1, input bit r1, input int rs2,
                         input bit r2, input int rd, input bit we,
                         input bit ld);
        id_v1 = 1; id_rs1_1 = rs1[4:0]; id_r1_1 = r1;
        id_rs2_1 = rs2[4:0]; id_r2_1 = r2;
        id_rd1 = rd[4:0]; id_we1 = we; id_ld1 = ld;
    endtask

    task automatic drain();
        idle(); mem_stall = 0; flush = 0;
        repeat (4) cycle();
    endtask

    task automatic rand_pair();
        bit w0, w1;
        idle();
        w0 = $urandom_range(0, 2) != 0;
        w1 = $urandom_range(0, 2) != 0;
        if ($urandom_range(0, 3) != 0)
            lane0($urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), w0,
                  w0 && $urandom_range(0, 2) == 0);
        if (id_v0 && $urandom_range(0, 2) != 0)
            lane1($urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), w1,
                  w1 && $urandom_range(0, 2) == 0);
    endtask

    task automatic async_reset_check();
        idle(); mem_stall = 0; flush = 0;
        #2 rst = 1;
        #1;
        chk("rst_wm0", wm0, 0); chk("rst_am0", am0, 0);
        chk("rst_wm1", wm1, 0); chk("rst_am1", am1, 0);
        chk("rst_ww0", ww0, 0); chk("rst_aw0", aw0, 0);
        chk("rst_ww1", ww1, 0); chk("rst_aw1", aw1, 0);
        chk("rst_stall", stall_id, 0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    initial begin
        rst = 1; mem_stall = 0; flush = 0;
        idle();
        model_reset();
        #2;
        chk("init_stall", stall_id, 0);
        chk("init_wm0", wm0, 0); chk("init_ww1", ww1, 0);
        @(posedge clk);
        #1 rst = 0;
        drain();

        // load-use: ld x5 then consumer of x5
        lane0(0, 0, 0, 0, 5, 1, 1);
        cycle();
        idle(); lane0(5, 1, 0, 0, 6, 1, 0);
        cycle();
        chk("lu_stall", c_st, 1); chk("lu_exv0", c_v0, 0);
        cycle();
        chk("lu_issue", c_v0, 1); chk("lu_wm0", c_wm0, 1);
        chk("lu_am0", c_am0, 5);
        drain();

        // intra-pair RAW on x3
        idle(); lane0(0, 0, 0, 0, 3, 1, 0); lane1(3, 1, 0, 0, 4, 1, 0);
        cycle();
        chk("raw_v0", c_v0, 1); chk("raw_v1", c_v1, 0);
        chk("raw_st", c_st, 1);
        cycle();
        chk("raw_v1b", c_v1, 1); chk("raw_stb", c_st, 0);
        idle();
        cycle(); cycle();
        chk("raw_ww0", c_ww0, 1); chk("raw_aw0", c_aw0, 3);
        chk("raw_wm1", c_wm1, 1); chk("raw_am1", c_am1, 4);
        drain();

        // WAW x7 splits; WAW x0 does not
        idle(); lane0(0, 0, 0, 0, 7, 1, 0); lane1(1, 1, 0, 0, 7, 1, 0);
        cycle();
        chk("waw_v1", c_v1, 0); chk("waw_st", c_st, 1);
        cycle();
        chk("waw_v1b", c_v1, 1);
        idle(); lane0(0, 0, 0, 0, 0, 1, 0); lane1(0, 1, 0, 1, 0, 1, 0);
        cycle();
        chk("x0_v0", c_v0, 1); chk("x0_v1", c_v1, 1);
        chk("x0_st", c_st, 0);
        drain();

        // mem_stall held three cycles while in SECOND
        idle(); lane0(0, 0, 0, 0, 3, 1, 0); lane1(3, 1, 0, 0, 9, 1, 0);
        cycle();
        mem_stall = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("ms_v1", c_v1, 0); chk("ms_st", c_st, 1);
        end
        mem_stall = 0;
        cycle();
        chk("ms_rel_v1", c_v1, 1); chk("ms_rel_st", c_st, 0);
        idle();
        cycle();
        chk("ms_once", c_v1, 0);
        drain();

        // flush while in SECOND
        idle(); lane0(0, 0, 0, 0, 3, 1, 0); lane1(3, 1, 0, 0, 9, 1, 0);
        cycle();
        flush = 1;
        cycle();
        chk("fl_v1", c_v1, 0); chk("fl_st", c_st, 0);
        flush = 0; idle();
        cycle();
        chk("fl_drain_wm0", c_wm0, 1);
        cycle();
        chk("fl_ex_clr", c_wm0, 0); chk("fl_ww0", c_ww0, 1);
        drain();

        // randomized traffic with one async reset mid-run
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                async_reset_check();
                idle();
                lane0(1, 1, 2, 1, 4, 1, 0); lane1(5, 1, 6, 1, 7, 1, 0);
                cycle();
                chk("rst_pair_v0", c_v0, 1);
                chk("rst_pair_v1", c_v1, 1);
            end
            if (!e_st) rand_pair();
            mem_stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 11) == 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
